// File: rtl/cache_pkg.sv
// Shared types, geometry and address-field helpers for the two-way
// write-through data cache.
package cache_pkg;

   localparam int SETS     = 64;
   localparam int TAG_W    = 10;
   localparam int INDEX_W  = 6;

   localparam int WORD_BIT = 2;
   localparam int INDEX_LO = 3;
   localparam int INDEX_HI = 8;
   localparam int TAG_LO   = 9;
   localparam int TAG_HI   = 18;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WRITE = 2'd2
   } cache_state_t;

   function automatic logic [INDEX_W-1:0] addr_index(input logic [31:0] addr);
      return addr[INDEX_HI:INDEX_LO];
   endfunction

   function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] addr);
      return addr[TAG_HI:TAG_LO];
   endfunction

   function automatic logic addr_word(input logic [31:0] addr);
      return addr[WORD_BIT];
   endfunction

endpackage

// File: rtl/cache_controller_if.sv
// MEM-stage request bus and SRAM-controller bus seen by the cache.
// master: the environment (pipeline + SRAM); slave: the cache.
interface cache_controller_if;
   import cache_pkg::*;

   logic [31:0] address;
   logic [31:0] wdata;
   logic        MEM_R_EN;
   logic        MEM_W_EN;
   logic [31:0] rdata;
   logic        ready;

   logic [31:0] sram_address;
   logic [31:0] sram_wdata;
   logic        sram_r_en;
   logic        sram_w_en;
   logic [63:0] sram_rdata;
   logic        sram_ready;

   modport master (
      output address, wdata, MEM_R_EN, MEM_W_EN, sram_rdata, sram_ready,
      input  rdata, ready, sram_address, sram_wdata, sram_r_en, sram_w_en
   );

   modport slave (
      input  address, wdata, MEM_R_EN, MEM_W_EN, sram_rdata, sram_ready,
      output rdata, ready, sram_address, sram_wdata, sram_r_en, sram_w_en
   );

endinterface

// File: rtl/cache_mem.sv
// Valid/tag/data storage for both ways plus one LRU bit per set.
// Combinational lookup port, single synchronous update port.
module cache_mem
   import cache_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [INDEX_W-1:0]    lookup_index,
   output logic [1:0]            lookup_valid,
   output logic [1:0][TAG_W-1:0] lookup_tag,
   output logic [1:0][63:0]      lookup_data,
   output logic                  lookup_lru,
   input  logic                  upd_en,
   input  logic [INDEX_W-1:0]    upd_index,
   input  logic                  upd_way,
   input  logic [1:0]            upd_word_mask,
   input  logic [63:0]           upd_data,
   input  logic [TAG_W-1:0]      upd_tag,
   input  logic                  upd_set_valid,
   input  logic                  upd_lru
);

   logic [SETS-1:0]  valid_r [2];
   logic [SETS-1:0]  lru_r;
   logic [TAG_W-1:0] tag_r   [2][SETS];
   logic [63:0]      data_r  [2][SETS];

   // Valid and LRU state: the only storage cleared by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_r[0] <= '0;
         valid_r[1] <= '0;
         lru_r      <= '0;
      end else if (upd_en) begin
         if (upd_set_valid) begin
            valid_r[upd_way][upd_index] <= 1'b1;
         end
         lru_r[upd_index] <= upd_lru;
      end
   end

   // Tag and data arrays, written per 32-bit word under the mask.
   always_ff @(posedge clk) begin
      if (upd_en) begin
         if (upd_set_valid) begin
            tag_r[upd_way][upd_index] <= upd_tag;
         end
         if (upd_word_mask[0]) begin
            data_r[upd_way][upd_index][31:0] <= upd_data[31:0];
         end
         if (upd_word_mask[1]) begin
            data_r[upd_way][upd_index][63:32] <= upd_data[63:32];
         end
      end
   end

   assign lookup_valid   = {valid_r[1][lookup_index], valid_r[0][lookup_index]};
   assign lookup_tag[0]  = tag_r[0][lookup_index];
   assign lookup_tag[1]  = tag_r[1][lookup_index];
   assign lookup_data[0] = data_r[0][lookup_index];
   assign lookup_data[1] = data_r[1][lookup_index];
   assign lookup_lru     = lru_r[lookup_index];

endmodule

// File: rtl/cache_controller.sv
// Two-way set-associative, write-through, no-write-allocate data cache.
// Hits answer in the request cycle; every SRAM access stalls the MEM stage.
module cache_controller
   import cache_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   cache_controller_if.slave  bus
);

   cache_state_t         state_r;

   logic [INDEX_W-1:0]   index_s;
   logic [TAG_W-1:0]     tag_s;
   logic                 word_s;
   logic [1:0]           lookup_valid_s;
   logic [1:0][TAG_W-1:0] lookup_tag_s;
   logic [1:0][63:0]     lookup_data_s;
   logic                 lookup_lru_s;
   logic [1:0]           hit_s;
   logic                 hit_any_s;
   logic                 hit_way_s;
   logic [63:0]          hit_line_s;
   logic [31:0]          hit_word_s;
   logic [31:0]          fill_word_s;
   logic                 victim_s;

   logic                 upd_req_s;
   logic                 upd_en_s;
   logic                 upd_way_s;
   logic [1:0]           upd_mask_s;
   logic [63:0]          upd_data_s;
   logic                 upd_set_valid_s;
   logic                 upd_lru_s;

   assign index_s = addr_index(bus.address);
   assign tag_s   = addr_tag(bus.address);
   assign word_s  = addr_word(bus.address);

   cache_mem u_mem (
      .clk           (clk),
      .rst           (rst),
      .lookup_index  (index_s),
      .lookup_valid  (lookup_valid_s),
      .lookup_tag    (lookup_tag_s),
      .lookup_data   (lookup_data_s),
      .lookup_lru    (lookup_lru_s),
      .upd_en        (upd_en_s),
      .upd_index     (index_s),
      .upd_way       (upd_way_s),
      .upd_word_mask (upd_mask_s),
      .upd_data      (upd_data_s),
      .upd_tag       (tag_s),
      .upd_set_valid (upd_set_valid_s),
      .upd_lru       (upd_lru_s)
   );

   assign hit_s[0]    = lookup_valid_s[0] && (lookup_tag_s[0] == tag_s);
   assign hit_s[1]    = lookup_valid_s[1] && (lookup_tag_s[1] == tag_s);
   assign hit_any_s   = |hit_s;
   assign hit_way_s   = hit_s[1];
   assign hit_line_s  = hit_way_s ? lookup_data_s[1] : lookup_data_s[0];
   assign hit_word_s  = word_s ? hit_line_s[63:32] : hit_line_s[31:0];
   assign fill_word_s = word_s ? bus.sram_rdata[63:32] : bus.sram_rdata[31:0];

   // A single invalid way is always filled first; otherwise LRU decides.
   always_comb begin
      case (lookup_valid_s)
         2'b01:   victim_s = 1'b1;
         2'b10:   victim_s = 1'b0;
         default: victim_s = lookup_lru_s;
      endcase
   end

   // Controller FSM; the SRAM completion pulse only matters in FILL/WRITE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.MEM_W_EN) begin
                  state_r <= WRITE;
               end else if (bus.MEM_R_EN && !hit_any_s) begin
                  state_r <= FILL;
               end else begin
                  state_r <= IDLE;
               end
            end
            FILL, WRITE: begin
               if (bus.sram_ready) begin
                  state_r <= IDLE;
               end else begin
                  state_r <= state_r;
               end
            end
            default: state_r <= IDLE;
         endcase
      end
   end

   // Handshake outputs and the storage update request for this cycle.
   always_comb begin
      bus.ready       = 1'b1;
      bus.rdata       = 32'd0;
      bus.sram_r_en   = 1'b0;
      bus.sram_w_en   = 1'b0;
      upd_req_s       = 1'b0;
      upd_way_s       = hit_way_s;
      upd_mask_s      = 2'b00;
      upd_data_s      = {bus.wdata, bus.wdata};
      upd_set_valid_s = 1'b0;
      upd_lru_s       = ~hit_way_s;
      case (state_r)
         IDLE: begin
            if (bus.MEM_W_EN) begin
               bus.ready     = 1'b0;
               bus.sram_w_en = 1'b1;
               if (hit_any_s) begin
                  upd_req_s  = 1'b1;
                  upd_mask_s = word_s ? 2'b10 : 2'b01;
               end else begin
                  upd_req_s  = 1'b0;
               end
            end else if (bus.MEM_R_EN) begin
               if (hit_any_s) begin
                  bus.rdata = hit_word_s;
                  upd_req_s = 1'b1;
               end else begin
                  bus.ready     = 1'b0;
                  bus.sram_r_en = 1'b1;
               end
            end else begin
               bus.ready = 1'b1;
            end
         end
         FILL: begin
            bus.sram_r_en   = 1'b1;
            upd_way_s       = victim_s;
            upd_lru_s       = ~victim_s;
            upd_mask_s      = 2'b11;
            upd_data_s      = bus.sram_rdata;
            upd_set_valid_s = 1'b1;
            if (bus.sram_ready) begin
               upd_req_s = 1'b1;
               bus.rdata = fill_word_s;
            end else begin
               bus.ready = 1'b0;
            end
         end
         WRITE: begin
            bus.sram_w_en = 1'b1;
            if (bus.sram_ready) begin
               bus.ready = 1'b1;
            end else begin
               bus.ready = 1'b0;
            end
         end
         default: begin
            bus.ready = 1'b1;
         end
      endcase
   end

   // Reset must win over any install or hit update in the same cycle.
   assign upd_en_s = upd_req_s && !rst;

   assign bus.sram_address = bus.MEM_W_EN ? bus.address : {bus.address[31:3], 3'b000};
   assign bus.sram_wdata   = bus.wdata;

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench: directed scenarios plus random traffic against a
// recency-list cache model and a sparse SRAM model.
module tb_cache_controller;
   import cache_pkg::*;

   logic clk = 1'b0;
   logic rst;

   cache_controller_if bus ();

   cache_controller dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int checks_n = 0;
   int fails_n  = 0;

   // Per set: up to two lines, position 0 is most recently used.
   int          m_cnt  [SETS];
   logic [9:0]  m_tag  [SETS][2];
   logic [63:0] m_data [SETS][2];
   logic [63:0] sram_mem [logic [28:0]];

   task automatic check_eq(input string name, input logic [63:0] obs, input logic [63:0] exp);
      checks_n++;
      if (obs !== exp) begin
         fails_n++;
         $display("FAIL %s: observed %0h expected %0h", name, obs, exp);
      end
   endtask

   task automatic m_reset();
      for (int s = 0; s < SETS; s++) m_cnt[s] = 0;
   endtask

   function automatic int m_find(input int idx, input logic [9:0] t);
      for (int p = 0; p < m_cnt[idx]; p++)
         if (m_tag[idx][p] == t) return p;
      return -1;
   endfunction

   task automatic m_touch(input int idx, input int p);
      logic [9:0]  t;
      logic [63:0] d;
      if (p == 1) begin
         t = m_tag[idx][1];  d = m_data[idx][1];
         m_tag[idx][1] = m_tag[idx][0];  m_data[idx][1] = m_data[idx][0];
         m_tag[idx][0] = t;  m_data[idx][0] = d;
      end
   endtask

   task automatic m_insert(input int idx, input logic [9:0] t, input logic [63:0] d);
      m_tag[idx][1] = m_tag[idx][0];
      m_data[idx][1] = m_data[idx][0];
      m_tag[idx][0] = t;
      m_data[idx][0] = d;
      if (m_cnt[idx] < 2) m_cnt[idx]++;
   endtask

   task automatic sram_get(input logic [28:0] k, output logic [63:0] line);
      if (!sram_mem.exists(k)) sram_mem[k] = {$urandom(), $urandom()};
      line = sram_mem[k];
   endtask

   function automatic logic [31:0] sel_word(input logic [63:0] line, input logic w);
      return w ? line[63:32] : line[31:0];
   endfunction

   task automatic idle_cycle();
      @(posedge clk); #1;
      bus.MEM_R_EN   = 1'b0;
      bus.MEM_W_EN   = 1'b0;
      bus.address    = $urandom();
      bus.sram_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      check_eq("idle_ready", 64'(bus.ready), 64'd1);
      check_eq("idle_r_en", 64'(bus.sram_r_en), 64'd0);
      check_eq("idle_w_en", 64'(bus.sram_w_en), 64'd0);
      check_eq("idle_rdata", 64'(bus.rdata), 64'd0);
   endtask

   task automatic do_read(input logic [31:0] addr, input int lat);
      int          idx;
      int          pos;
      logic [9:0]  t;
      logic        w;
      logic [63:0] line;
      idx = int'(addr[8:3]);
      t   = addr[18:9];
      w   = addr[2];
      pos = m_find(idx, t);
      @(posedge clk); #1;
      bus.address = addr; bus.MEM_R_EN = 1'b1; bus.MEM_W_EN = 1'b0; bus.sram_ready = 1'b0;
      @(negedge clk);
      if (pos >= 0) begin
         check_eq("rd_hit_ready", 64'(bus.ready), 64'd1);
         check_eq("rd_hit_rdata", 64'(bus.rdata), 64'(sel_word(m_data[idx][pos], w)));
         check_eq("rd_hit_no_sram", 64'({bus.sram_r_en, bus.sram_w_en}), 64'd0);
         m_touch(idx, pos);
      end else begin
         sram_get(addr[31:3], line);
         check_eq("rd_miss_ready", 64'(bus.ready), 64'd0);
         check_eq("rd_miss_r_en", 64'(bus.sram_r_en), 64'd1);
         check_eq("rd_miss_w_en", 64'(bus.sram_w_en), 64'd0);
         check_eq("rd_miss_addr", 64'(bus.sram_address), 64'({addr[31:3], 3'b000}));
         for (int k = 1; k <= lat; k++) begin
            @(posedge clk); #1;
            bus.sram_ready = (k == lat);
            bus.sram_rdata = (k == lat) ? line : 64'(~line);
            @(negedge clk);
            check_eq("fill_r_en", 64'(bus.sram_r_en), 64'd1);
            check_eq("fill_ready", 64'(bus.ready), (k == lat) ? 64'd1 : 64'd0);
            if (k == lat) check_eq("fill_rdata", 64'(bus.rdata), 64'(sel_word(line, w)));
         end
         m_insert(idx, t, line);
      end
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input int lat,
                           input logic both);
      int          idx;
      int          pos;
      logic [63:0] line;
      idx = int'(addr[8:3]);
      pos = m_find(idx, addr[18:9]);
      @(posedge clk); #1;
      bus.address = addr; bus.wdata = data; bus.MEM_W_EN = 1'b1; bus.MEM_R_EN = both;
      bus.sram_ready = 1'b0;
      @(negedge clk);
      check_eq("wr_ready", 64'(bus.ready), 64'd0);
      check_eq("wr_w_en", 64'(bus.sram_w_en), 64'd1);
      check_eq("wr_r_en", 64'(bus.sram_r_en), 64'd0);
      check_eq("wr_addr", 64'(bus.sram_address), 64'(addr));
      check_eq("wr_wdata", 64'(bus.sram_wdata), 64'(data));
      for (int k = 1; k <= lat; k++) begin
         @(posedge clk); #1;
         bus.sram_ready = (k == lat);
         @(negedge clk);
         check_eq("wr_wait_ready", 64'(bus.ready), (k == lat) ? 64'd1 : 64'd0);
         check_eq("wr_wait_r_en", 64'(bus.sram_r_en), 64'd0);
         if (k < lat) check_eq("wr_wait_w_en", 64'(bus.sram_w_en), 64'd1);
      end
      sram_get(addr[31:3], line);
      if (addr[2]) line[63:32] = data; else line[31:0] = data;
      sram_mem[addr[31:3]] = line;
      if (pos >= 0) begin
         if (addr[2]) m_data[idx][pos][63:32] = data; else m_data[idx][pos][31:0] = data;
         m_touch(idx, pos);
      end
   endtask

   task automatic reset_in_fill(input logic [31:0] addr);
      @(posedge clk); #1;
      bus.address = addr; bus.MEM_R_EN = 1'b1; bus.MEM_W_EN = 1'b0; bus.sram_ready = 1'b0;
      @(negedge clk);
      check_eq("rst_pre_r_en", 64'(bus.sram_r_en), 64'd1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      bus.MEM_R_EN = 1'b0;
      m_reset();
      @(negedge clk);
      check_eq("rst_post_r_en", 64'(bus.sram_r_en), 64'd0);
      check_eq("rst_post_w_en", 64'(bus.sram_w_en), 64'd0);
      check_eq("rst_post_ready", 64'(bus.ready), 64'd1);
   endtask

   initial begin
      logic [31:0] a;
      int          op;
      rst = 1'b1;
      bus.address = 32'd0; bus.wdata = 32'd0; bus.MEM_R_EN = 1'b0; bus.MEM_W_EN = 1'b0;
      bus.sram_rdata = 64'd0; bus.sram_ready = 1'b0;
      m_reset();
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_eq("reset_ready", 64'(bus.ready), 64'd1);
      check_eq("reset_r_en", 64'(bus.sram_r_en), 64'd0);
      check_eq("reset_w_en", 64'(bus.sram_w_en), 64'd0);
      check_eq("reset_rdata", 64'(bus.rdata), 64'd0);

      // Cold read then same-line hit
      sram_mem[29'(32'h0000_0408 >> 3)] = 64'hBBBB_BBBB_AAAA_AAAA;
      do_read(32'h0000_0408, 3);
      do_read(32'h0000_040C, 1);

      // Three tags in set 5: LRU replacement
      do_read(32'h0000_0228, 2);
      do_read(32'h0000_0428, 1);
      do_read(32'h0000_0628, 4);
      do_read(32'h0000_0428, 1);
      do_read(32'h0000_0228, 2);

      // Write hit, write miss, simultaneous enables
      do_write(32'h0000_042C, 32'h1234_5678, 3, 1'b0);
      do_read(32'h0000_042C, 1);
      do_write(32'h0000_0E48, 32'hCAFE_F00D, 2, 1'b0);
      do_read(32'h0000_0E48, 2);
      do_write(32'h0000_1050, 32'h5A5A_A5A5, 2, 1'b1);
      do_read(32'h0000_1050, 1);
      idle_cycle();

      // Reset during a fill
      reset_in_fill(32'h0007_FE00);
      do_read(32'h0007_FE00, 2);
      do_read(32'h0000_0408, 1);

      for (int n = 0; n < 400; n++) begin
         a = {13'd0, 10'($urandom_range(0, 3)), 6'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))};
         op = $urandom_range(0, 8);
         if (op <= 4)      do_read(a, $urandom_range(1, 4));
         else if (op <= 6) do_write(a, $urandom(), $urandom_range(1, 4), 1'b0);
         else if (op == 7) do_write(a, $urandom(), $urandom_range(1, 4), 1'b1);
         else              idle_cycle();
      end
      idle_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", checks_n, fails_n);
      $finish;
   end

endmodule
